// File: rtl/html_stream_ctrl_pkg.sv
// Shared types and constants for the HTML char stream controller.
// Defines the FSM state enum, the char width (HTML_CHAR_W) and marker chars.
`ifndef HTML_CHAR_W
`define HTML_CHAR_W 8
`endif

package html_stream_ctrl_pkg;

    localparam int CHAR_W = `HTML_CHAR_W;

    localparam logic [7:0] EOF_CHAR = 8'hFF;
    localparam logic [7:0] CR_CHAR  = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/html_stream_ctrl_char_fifo.sv
// Synchronous char FIFO, power-of-two depth, registered storage.
// Ports: clock, reset, push/din, pop/dout, count, full, empty.
module char_fifo #(
    parameter int CHAR_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [CHAR_W-1:0] din,
    input  logic              pop,
    output logic [CHAR_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is forced to zero when empty so the output is clean after reset.
    assign dout = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/html_stream_ctrl.sv
// Sequences the HTML char reader into a FIFO and a valid/ready char stream.
// Ports: clock/reset/start; rd_* reader link; out_* stream; busy/done/char_count.
// Optional HTML_STREAM_CR_STRIP_EN: captured 0x0D chars are dropped.
module html_stream_ctrl #(
    parameter int CHAR_W = html_stream_ctrl_pkg::CHAR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              rd_enable,
    output logic              rd_pause,
    input  logic [CHAR_W-1:0] rd_char,
    input  logic              rd_finished,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_char,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  char_count
);

    import html_stream_ctrl_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q;
    state_e            state_d;
    logic              fetch_pending_q;
    logic [CNT_W-1:0]  count_q;
    logic              cnt_clr;

    logic              push;
    logic              pop;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW:0]       inflight;
    logic              credit_full;
    logic              keep_char;

    // Slots already reserved: stored entries plus the fetch in flight.
    // Pops in the same cycle are not credited back.
    assign inflight    = {1'b0, fifo_count} + (CW+1)'(fetch_pending_q);
    assign credit_full = (inflight >= (CW+1)'(DEPTH));

`ifdef HTML_STREAM_CR_STRIP_EN
    assign keep_char = (rd_char != CHAR_W'(CR_CHAR));
`else
    assign keep_char = 1'b1;
`endif

    // The EOF read arrives with rd_finished high and is never stored.
    assign push = fetch_pending_q
               && (state_q == S_STREAM)
               && !rd_finished
               && keep_char;

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign busy       = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign char_count = count_q;

    always_comb begin
        state_d   = state_q;
        rd_enable = 1'b0;
        rd_pause  = 1'b1;
        cnt_clr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    cnt_clr = 1'b1;
                end
            end
            S_STREAM: begin
                rd_enable = 1'b1;
                rd_pause  = credit_full || rd_finished;
                if (rd_finished) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rd_enable = 1'b1;
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rd_enable = 1'b1;
                if (start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            fetch_pending_q <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pending_q <= rd_enable && !rd_pause;
            if (cnt_clr) begin
                count_q <= '0;
            end else if (pop && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    char_fifo #(
        .CHAR_W (CHAR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (rd_char),
        .pop   (pop),
        .dout  (out_char),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_html_stream_ctrl.sv
// Self-checking bench for html_stream_ctrl with a behavioural reader
// and a queue-based model of the expected delivered stream.
module tb_html_stream_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
    logic        rd_enable;
    logic        rd_pause;
    logic [7:0]  rd_char = 8'h00;
    logic        rd_finished = 1'b0;
    logic        out_valid;
    logic [7:0]  out_char;
    logic        busy;
    logic        done;
    logic [15:0] char_count;

    int checks   = 0;
    int failures = 0;

    byte unsigned file_q[$];
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int           ridx = 0;

    int first_xfer;
    int last_xfer;
    int done_cyc;
    int ridx_at15;
    bit pause_at15;
    bit valid_seen;
    bit ff_seen;
    bit timeout;

    always #5 clock = ~clock;

    html_stream_ctrl #(
        .CHAR_W (8),
        .DEPTH  (4),
        .CNT_W  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rd_enable   (rd_enable),
        .rd_pause    (rd_pause),
        .rd_char     (rd_char),
        .rd_finished (rd_finished),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .busy        (busy),
        .done        (done),
        .char_count  (char_count)
    );

    // Reader: one char per enabled, un-paused clock; 0xFF + finished at EOF.
    always @(posedge clock) begin
        if (!rd_enable) begin
            ridx        <= 0;
            rd_char     <= 8'h00;
            rd_finished <= 1'b0;
        end else if (!rd_pause) begin
            if (ridx < file_q.size()) begin
                rd_char <= file_q[ridx];
                ridx    <= ridx + 1;
            end else begin
                rd_char     <= 8'hFF;
                rd_finished <= 1'b1;
            end
        end
    end

    function automatic void build_exp();
        exp_q = {};
        foreach (file_q[i]) begin
`ifdef HTML_STREAM_CR_STRIP_EN
            if (file_q[i] == 8'h0D) continue;
`endif
            exp_q.push_back(file_q[i]);
        end
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Pulses start, then drives out_ready per mode until done.
    // mode 0: always ready, 1: stalled 20 cycles, 2: toggling, 3: random.
    task automatic run_stream(input int mode, input int max_cyc);
        bit          held;
        byte unsigned held_c;
        int          cyc;
        got_q      = {};
        first_xfer = -1;
        last_xfer  = -1;
        done_cyc   = -1;
        ridx_at15  = -1;
        pause_at15 = 1'b0;
        valid_seen = 1'b0;
        ff_seen    = 1'b0;
        timeout    = 1'b1;
        held       = 1'b0;
        held_c     = 8'h00;
        @(negedge clock);
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (cyc <= max_cyc) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc > 20);
                2:       out_ready = ((cyc % 2) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_char !== held_c) begin
                    failures++;
                    $display("FAIL hold cyc=%0d got v=%b c=%h need v=1 c=%h",
                             cyc, out_valid, out_char, held_c);
                end
            end
            if (cyc == 15) begin
                ridx_at15  = ridx;
                pause_at15 = rd_pause;
            end
            if (out_valid) valid_seen = 1'b1;
            if (out_valid && out_ready) begin
                got_q.push_back(out_char);
                if (out_char == 8'hFF) ff_seen = 1'b1;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
            held   = out_valid && !out_ready;
            held_c = out_char;
            if (done) begin
                done_cyc = cyc;
                timeout  = 1'b0;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL timeout done=%b need done=1 within %0d cycles",
                     done, max_cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (rd_enable !== 1'b0) begin
            failures++;
            $display("FAIL rst_rd_enable got=%b need=0", rd_enable);
        end
        if (rd_pause !== 1'b1) begin
            failures++;
            $display("FAIL rst_rd_pause got=%b need=1", rd_pause);
        end
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b need=0", out_valid);
        end
        if (out_char !== 8'h00) begin
            failures++;
            $display("FAIL rst_out_char got=%h need=00", out_char);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got=%b need=0", busy);
        end
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rst_done got=%b need=0", done);
        end
        if (char_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_count got=%0d need=0", char_count);
        end
    endtask

    task automatic test_abc();
        do_reset();
        file_q = {8'h61, 8'h62, 8'h63};
        build_exp();
        run_stream(0, 100);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL abc_len got=%0d need=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL abc_char[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks += 4;
        if (last_xfer - first_xfer != 2) begin
            failures++;
            $display("FAIL abc_consec got span=%0d need=2", last_xfer - first_xfer);
        end
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL abc_done got=%b need=1", done);
        end
        if (char_count !== 16'd3) begin
            failures++;
            $display("FAIL abc_count got=%0d need=3", char_count);
        end
        if (ff_seen) begin
            failures++;
            $display("FAIL abc_no_eof got=FF delivered need=none");
        end
    endtask

    task automatic test_restart();
        // DONE + start goes to IDLE with the reader held in reset.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks += 3;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL restart_idle got done=%b busy=%b need 0 0", done, busy);
        end
        if (rd_enable !== 1'b0) begin
            failures++;
            $display("FAIL restart_rd_enable got=%b need=0", rd_enable);
        end
        file_q = {8'h78, 8'h79};
        build_exp();
        run_stream(0, 100);
        if (char_count !== 16'd2 || got_q.size() != 2) begin
            failures++;
            $display("FAIL restart_stream got count=%0d n=%0d need 2 2",
                     char_count, got_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        file_q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        build_exp();
        run_stream(1, 200);
        checks += 3;
        if (pause_at15 !== 1'b1) begin
            failures++;
            $display("FAIL bp_pause got=%b need=1", pause_at15);
        end
        if (ridx_at15 != 4) begin
            failures++;
            $display("FAIL bp_reads got=%0d need=4", ridx_at15);
        end
        if (char_count !== 16'd8) begin
            failures++;
            $display("FAIL bp_count got=%0d need=8", char_count);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_len got=%0d need=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL bp_char[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        file_q = {};
        run_stream(0, 50);
        checks += 3;
        if (valid_seen) begin
            failures++;
            $display("FAIL empty_valid got=1 need=never");
        end
        if (done_cyc < 0 || done_cyc > 4) begin
            failures++;
            $display("FAIL empty_latency got=%0d need<=4", done_cyc);
        end
        if (char_count !== 16'd0) begin
            failures++;
            $display("FAIL empty_count got=%0d need=0", char_count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        file_q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        @(negedge clock);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks += 4;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mrst_state got busy=%b done=%b need 0 0", busy, done);
        end
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mrst_valid got=%b need=0", out_valid);
        end
        if (rd_enable !== 1'b0) begin
            failures++;
            $display("FAIL mrst_rd_enable got=%b need=0", rd_enable);
        end
        if (char_count !== 16'd0) begin
            failures++;
            $display("FAIL mrst_count got=%0d need=0", char_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_cr();
        do_reset();
        file_q = {8'h61, 8'h0D, 8'h0A, 8'h62};
        build_exp();
        run_stream(0, 100);
        checks++;
        if (char_count !== 16'(exp_q.size()) || got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL cr_count got=%0d n=%0d need=%0d",
                     char_count, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL cr_char[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        file_q = {8'h61, 8'h62, 8'h63, 8'h64};
        build_exp();
        run_stream(2, 100);
        checks++;
        if (got_q.size() != exp_q.size() || char_count !== 16'd4) begin
            failures++;
            $display("FAIL tog_len got n=%0d count=%0d need 4 4",
                     got_q.size(), char_count);
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL tog_char[%0d] got=%h need=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int len;
            do_reset();
            len    = $urandom_range(0, 12);
            file_q = {};
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) file_q.push_back(8'h0D);
                else file_q.push_back(8'($urandom_range(0, 254)));
            end
            build_exp();
            run_stream(3, 400);
            checks++;
            if (got_q.size() != exp_q.size() || char_count !== 16'(exp_q.size())) begin
                failures++;
                $display("FAIL rnd%0d_len got n=%0d count=%0d need=%0d",
                         it, got_q.size(), char_count, exp_q.size());
            end
            foreach (exp_q[i]) begin
                if (i < got_q.size()) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rnd%0d_char[%0d] got=%h need=%h",
                                 it, i, got_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_abc();
        test_restart();
        test_backpressure();
        test_empty();
        test_mid_reset();
        test_cr();
        test_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
